instruction_fetch_memory: RTL and testbench

INSTRUCTION_FETCH_MEMORY -- requirements
Module: instruction_fetch_memory

---
 rtl/instruction_fetch_memory.sv | 86 ++++++++
 tb/tb_instruction_fetch_memory.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_memory.sv
// Byte-addressed instruction memory with a one-deep valid/ready fetch response.
// Define IMEM_LOAD_EN to add the byte-load port (ld_en/ld_addr/ld_data); otherwise the array is an all-zero ROM.
module instruction_fetch_memory #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] A,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] RD,
  output logic        fault_misalign,
  output logic        fault_range
`ifdef IMEM_LOAD_EN
  ,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [7:0]  ld_data
`endif
);

  localparam int unsigned AW            = $clog2(DEPTH_BYTES);
  localparam logic [31:0] LAST_WORD_OFF = 32'(DEPTH_BYTES - 4);

  logic [7:0]    mem [DEPTH_BYTES];
  logic [31:0]   off;
  logic [AW-3:0] word_idx;
  logic [31:0]   word_c;
  logic          misalign_c;
  logic          range_c;
  logic          accept;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
  assign off        = A - BASE_ADDR;
  assign misalign_c = (A[1:0] != 2'b00);
  assign range_c    = (off > LAST_WORD_OFF);
  assign word_idx   = off[AW-1:2];
  assign word_c     = {mem[{word_idx, 2'b11}], mem[{word_idx, 2'b10}],
                       mem[{word_idx, 2'b01}], mem[{word_idx, 2'b00}]};
  assign accept     = req_valid && req_ready;

`ifdef IMEM_LOAD_EN
  localparam logic [31:0] DEPTH_W = 32'(DEPTH_BYTES);

  logic [31:0] ld_off;

  assign ld_off    = ld_addr - BASE_ADDR;
  // A load occupies the array port, so it blocks a fetch in the same cycle.
  assign req_ready = (!rsp_valid || rsp_ready) && !ld_en;

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ld_en && (ld_off < DEPTH_W)) begin
      mem[ld_off[AW-1:0]] <= ld_data;
    end
  end
`else
  assign req_ready = !rsp_valid || rsp_ready;

  for (genvar i = 0; i < int'(DEPTH_BYTES); i++) begin : g_rom
    assign mem[i] = 8'h00;
  end
`endif

  // Response register: loads on accept, holds while stalled, clears on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid      <= 1'b0;
      RD             <= 32'h0;
      fault_misalign <= 1'b0;
      fault_range    <= 1'b0;
    end else if (accept) begin
      rsp_valid      <= 1'b1;
      RD             <= (misalign_c || range_c) ? NOP_WORD : word_c;
      fault_misalign <= misalign_c;
      fault_range    <= range_c;
    end else if (rsp_ready) begin
      rsp_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Directed bench for instruction_fetch_memory with a response scoreboard.
module tb_instruction_fetch_memory;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] rd;
    logic        mis;
    logic        rng;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] A;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] RD;
  logic        fault_misalign;
  logic        fault_range;
`ifdef IMEM_LOAD_EN
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [7:0]  ld_data;
`endif

  int          errors = 0;
  int          checks = 0;
  rsp_t        sb[$];
  logic [7:0]  model_mem [DEPTH];
  logic [7:0]  pat [12] = '{8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h11, 8'h22,
                            8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic        b2b_rng [3] = '{1'b1, 1'b1, 1'b0};
  logic [31:0] b2b_addr [3] = '{32'h0000_0FFC, 32'h0000_1400, 32'h0000_13FC};

  instruction_fetch_memory dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .A              (A),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .RD             (RD),
    .fault_misalign (fault_misalign),
    .fault_range    (fault_range)
`ifdef IMEM_LOAD_EN
    ,
    .ld_en          (ld_en),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t model_rsp(input logic [31:0] a);
    rsp_t        r;
    logic [31:0] o;
    o     = a - BASE;
    r.mis = (a[1:0] != 2'b00);
    r.rng = (o > 32'(DEPTH - 4));
    if (r.mis || r.rng) r.rd = NOP;
    else r.rd = {model_mem[o[9:0] + 10'd3], model_mem[o[9:0] + 10'd2],
                 model_mem[o[9:0] + 10'd1], model_mem[o[9:0]]};
    return r;
  endfunction

  // Evaluate handshakes just before the rising edge, then advance to the next falling edge.
  task automatic cycle();
    rsp_t e;
    #1;
    if (rsp_valid && rsp_ready) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_rd", RD, e.rd);
        chk("sb_misalign", 32'(fault_misalign), 32'(e.mis));
        chk("sb_range", 32'(fault_range), 32'(e.rng));
      end
    end
    if (req_valid && req_ready) sb.push_back(model_rsp(A));
`ifdef IMEM_LOAD_EN
    if (ld_en && ((ld_addr - BASE) < 32'(DEPTH))) model_mem[10'(ld_addr - BASE)] = ld_data;
`endif
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; A = 32'h0; rsp_ready = 1'b0;
`ifdef IMEM_LOAD_EN
    ld_en = 1'b0; ld_addr = 32'h0; ld_data = 8'h0;
`endif
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 8'h00;

    // Reset state before any clock edge
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rd", RD, 32'h0);
    chk("rst_misalign", 32'(fault_misalign), 32'd0);
    chk("rst_range", 32'(fault_range), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef IMEM_LOAD_EN
    for (int i = 0; i < 12; i++) begin
      ld_en = 1'b1; ld_addr = BASE + 32'(i); ld_data = pat[i];
      if (i == 0) begin
        #1;
        chk("req_ready_during_load", 32'(req_ready), 32'd0);
      end
      cycle();
    end
    ld_en = 1'b0;
`endif

    // Single fetch, latency 1
    req_valid = 1'b1; A = 32'h0000_1000; rsp_ready = 1'b1;
    #1;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    cycle();
    req_valid = 1'b0;
    chk("rsp_valid_lat1", 32'(rsp_valid), 32'd1);
`ifdef IMEM_LOAD_EN
    chk("rd_1000", RD, 32'hFFC4A303);
`endif
    cycle();
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);

    // Backpressure: hold first response, second request waits
    rsp_ready = 1'b0; req_valid = 1'b1; A = 32'h0000_1000;
    cycle();
    A = 32'h0000_1004;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rd", RD, sb[0].rd);
      cycle();
    end
`ifdef IMEM_LOAD_EN
    chk("stall_rd_const", RD, 32'hFFC4A303);
`endif
    rsp_ready = 1'b1;
    #1;
    chk("unstall_req_ready", 32'(req_ready), 32'd1);
    cycle();
    req_valid = 1'b0;
    chk("second_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("second_rd", RD, sb[0].rd);
    cycle();

    // Misaligned fetch
    req_valid = 1'b1; A = 32'h0000_1002;
    cycle();
    req_valid = 1'b0;
    chk("mis_flag", 32'(fault_misalign), 32'd1);
    chk("mis_range_flag", 32'(fault_range), 32'd0);
    chk("mis_rd", RD, NOP);
    cycle();

    // Range boundaries, back-to-back
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = b2b_addr[i];
      #1;
      chk("b2b_req_ready", 32'(req_ready), 32'd1);
      if (i > 0) chk("b2b_range", 32'(fault_range), 32'(b2b_rng[i-1]));
      cycle();
    end
    req_valid = 1'b0;
    chk("b2b_last_range", 32'(fault_range), 32'd0);
    cycle();

`ifdef IMEM_LOAD_EN
    // Load wins over a simultaneous fetch
    req_valid = 1'b1; A = 32'h0000_1004;
    ld_en = 1'b1; ld_addr = 32'h0000_1004; ld_data = 8'h5A;
    #1;
    chk("ld_wins_req_ready", 32'(req_ready), 32'd0);
    cycle();
    ld_en = 1'b0;
    #1;
    chk("after_ld_req_ready", 32'(req_ready), 32'd1);
    cycle();
    req_valid = 1'b0;
    chk("rd_after_ld", RD, 32'h4433225A);
    cycle();

    // Out-of-range loads are ignored (no aliasing into the array)
    ld_en = 1'b1; ld_addr = 32'h0000_1400; ld_data = 8'h77;
    cycle();
    ld_addr = 32'h0000_0FFF; ld_data = 8'hEE;
    cycle();
    ld_en = 1'b0; req_valid = 1'b1; A = 32'h0000_1000;
    cycle();
    req_valid = 1'b0;
    chk("oor_ld_ignored", RD, 32'hFFC4A303);
    cycle();

    // Load under a held response does not disturb registered RD
    rsp_ready = 1'b0; req_valid = 1'b1; A = 32'h0000_1008;
    cycle();
    req_valid = 1'b0; ld_en = 1'b1; ld_addr = 32'h0000_1008; ld_data = 8'hC3;
    cycle();
    ld_en = 1'b0;
    chk("rd_hold_ld", RD, 32'h88776655);
    rsp_ready = 1'b1;
    cycle();
    req_valid = 1'b1; A = 32'h0000_1008;
    cycle();
    req_valid = 1'b0;
    chk("rd_new_byte", RD, 32'h887766C3);
    cycle();
`endif

    // Asynchronous reset with a pending response
    rsp_ready = 1'b0; req_valid = 1'b1; A = 32'h0000_1000;
    cycle();
    req_valid = 1'b0;
    chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_rd", RD, 32'h0);
    chk("async_rst_misalign", 32'(fault_misalign), 32'd0);
    chk("async_rst_range", 32'(fault_range), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1; req_valid = 1'b1; A = 32'h0000_1000;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    cycle();
    req_valid = 1'b0;
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd1);
`ifdef IMEM_LOAD_EN
    chk("mem_survives_rst", RD, 32'hFFC4A303);
`endif
    cycle();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
